// File: rtl/mul_seq4.sv
// rtl/mul_seq4.sv - sequenced WxW unsigned multiplier over one shared 4x4 core (option: ZERO_SKIP_EN)

// 4x4 unsigned array multiplier core; the full 8-bit product including Z[7].
module mul_seq4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] z
);
  assign z = 8'(a) * 8'(b);
endmodule

module mul_seq4 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);
  localparam int D  = W / 4;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_r, b_r;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  i, j;
  logic [3:0]     nib_a, nib_b;
  logic [7:0]     z;
  logic [CW:0]    pos;
  logic [2*W-1:0] partial;
  logic           accept;
  logic           last;
  logic           i_wrap;
  logic           zero_in;

  // Nibble selection and placement of the current partial product.
  assign nib_a   = a_r[{i, 2'b00} +: 4];
  assign nib_b   = b_r[{j, 2'b00} +: 4];
  assign pos     = {1'b0, i} + {1'b0, j};
  assign partial = (2*W)'(z) << {pos, 2'b00};
  assign i_wrap  = (i == CW'(D - 1));
  assign last    = i_wrap && (j == CW'(D - 1));

  mul_seq4_core ra (
    .a (nib_a),
    .b (nib_b),
    .z (z)
  );

`ifdef ZERO_SKIP_EN
  // A zero operand makes the product trivially zero, so the passes are skipped.
  assign zero_in = (a == '0) || (b == '0);
`else
  assign zero_in = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign p      = acc;
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; in DONE a new pair may enter in the retire cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = zero_in ? DONE : MUL;
      end
      MUL: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_next = zero_in ? DONE : MUL;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, nibble counters and shift-accumulate of one core pass per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (state == MUL) begin
      acc <= acc + partial;
      if (i_wrap) begin
        i <= '0;
        j <= j + CW'(1);
      end else begin
        i <= i + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mul_seq4.sv
// tb/tb_mul_seq4.sv - scoreboard bench for mul_seq4 with directed and random stimulus
module tb_mul_seq4;
  localparam int W = 8;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        iv4, ir4, ov4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        iv16, ir16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq4 #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  mul_seq4 #(.W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(1'b1), .p(p4), .busy(busy4)
  );

  mul_seq4 #(.W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(1'b1), .p(p16), .busy(busy16)
  );

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one pair, push its expected product, and measure edges from accept to out_valid.
  task automatic send(input logic [7:0] x, input logic [7:0] y, output int lat);
    int t;
    a = x;
    b = y;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) check("send_in_ready_timeout", 0, 1);
    @(posedge clk);
    exp_q.push_back(model(x, y));
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold behaviour under stall.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_p = '0;
  logic [15:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_p", p, prev_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("product", p, exp_v);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = p;
    end
  end

  initial begin
    int  lat, t, accepted;
    bit  ok, fire;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    iv4 = 1'b0; a4 = '0; b4 = '0; iv16 = 1'b0; a16 = '0; b16 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_p", p, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    tick();

    // Basic products and latency
    send(8'h12, 8'h34, lat);
    check("lat_12x34", lat, N);
    check("p_12x34", p, 16'h03A8);
    tick();
    send(8'hFF, 8'hFF, lat);
    check("lat_ffxff", lat, N);
    check("p_ffxff", p, 16'hFE01);
    tick();

    // Backpressure
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, lat);
    check("bp_lat", lat, N);
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!(out_valid && p == 16'hFE01 && !in_ready)) ok = 1'b0;
      tick();
    end
    check("bp_held", ok, 1);
    out_ready = 1'b1;
    tick();

    // Back-to-back
    a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h00E1);
    #1;
    a = 8'hA5; b = 8'h3C;
    ok = 1'b1;
    t = 0;
    while (!(out_valid && in_ready) && t < 30) begin
      if (!busy) ok = 1'b0;
      tick();
      t++;
    end
    check("b2b_first_lat", t, N);
    check("b2b_first_p", p, 16'h00E1);
    @(posedge clk);
    exp_q.push_back(16'h26AC);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 30) begin
      if (!busy) ok = 1'b0;
      tick();
      t++;
    end
    check("b2b_spacing", t + 1, N + 1);
    check("b2b_busy", ok, 1);
    check("b2b_second_p", p, 16'h26AC);
    tick();

    // Reset during the second MUL pass
    a = 8'hFF; b = 8'h02; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_p", p, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      if (out_valid) ok = 1'b0;
      tick();
    end
    check("rst_no_stale_valid", ok, 1);

    // Zero operand
    send(8'h00, 8'hAB, lat);
`ifdef ZERO_SKIP_EN
    check("zero_lat", lat, 0);
`else
    check("zero_lat", lat, N);
`endif
    check("zero_p", p, 0);
    tick();

    // Other widths
    a4 = 4'd3; b4 = 4'd5; iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    t = 0;
    while (!ov4 && t < 50) begin
      tick();
      t++;
    end
    check("w4_lat", t, 1);
    check("w4_p", p4, 8'h0F);
    tick();
    a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    t = 0;
    while (!ov16 && t < 50) begin
      tick();
      t++;
    end
    check("w16_lat", t, 16);
    check("w16_p", p16, 32'hFFFE0001);
    tick();

    // Random traffic with random consumer stalls
    accepted = 0;
    fire = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && accepted < 40; c++) begin
      @(posedge clk);
      if (fire) begin
        exp_q.push_back(model(a, b));
        accepted++;
      end
      #1;
      if (fire || !in_valid) begin
        in_valid = ($urandom % 3) != 0;
        a = 8'($urandom);
        b = 8'($urandom);
        if ($urandom % 8 == 0) a = 8'h00;
        if ($urandom % 8 == 0) b = 8'hFF;
      end
      out_ready = ($urandom % 4) != 0;
      #1;
      fire = in_valid && in_ready;
    end
    check("rand_accepted", accepted, 40);

    // Drain
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
